inv_key_schedule: RTL and testbench

- Iterative AES key expansion plus round-key server for the inverse cipher datapath.
- Accepts a cipher key and expands it one 32-bit word per clock into an internal word store.
- Then serves 128-bit round keys in reverse order (round Nr down to round 0), one per request, to the inverse-round stages.
- Sits directly upstream of the inverse-round key input; the decryption controller issues the requests.

---
 rtl/inv_key_schedule.sv | 168 ++++++++++++++++
 tb/tb_inv_key_schedule.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/inv_key_schedule.sv
// AES key expansion (one word per clock) followed by a round-key server that
// hands out round keys from round Nr down to round 0, wrapping for the next block.
module inv_key_schedule #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [32*Nk-1:0]  key_in,
    input  logic              key_load,
    input  logic              rk_req,
    output logic              busy,
    output logic              ready,
    output logic [127:0]      rk_out,
    output logic              rk_valid,
    output logic [3:0]        rk_index,
    output logic              rk_last
);
    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW);
    localparam logic [IW-1:0] LAST_I = IW'(NW - 1);
    localparam logic [IW-1:0] NK_I   = IW'(Nk);
    localparam logic [2:0]    NK_J   = 3'(Nk - 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        logic [31:0] y;
        for (int b = 0; b < 4; b++) begin
            y[8*b +: 8] = SBOX[x[8*b +: 8]];
        end
        return y;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        r_state;
    logic [IW-1:0] r_i;
    logic [2:0]    r_j;
    logic [7:0]    r_rcon;
    logic [3:0]    r_p;
    logic          r_busy;
    logic          r_ready;
    logic [127:0]  r_rk_out;
    logic          r_rk_valid;
    logic [3:0]    r_rk_index;
    logic          r_rk_last;
    logic [31:0]   r_w [NW];

    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_temp;
    logic [31:0]   w_new;

    // Next expanded word from w[i-1] and w[i-Nk]; r_j tracks i mod Nk.
    always_comb begin
        w_prev = r_w[r_i - IW'(1)];
        w_back = r_w[r_i - NK_I];
        if (r_j == 3'd0) begin
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h000000};
        end else if ((Nk == 8) && (r_j == 3'd4)) begin
            w_temp = sub_word(w_prev);
        end else begin
            w_temp = w_prev;
        end
        w_new = w_back ^ w_temp;
    end

    // Word store: bulk key write on load, one expanded word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (key_load) begin
            for (int k = 0; k < Nk; k++) begin
                r_w[k] <= key_in[32*(Nk-1-k) +: 32];
            end
        end else if (r_state == EXPAND) begin
            r_w[r_i] <= w_new;
        end
    end

    // Control FSM and registered round-key outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_i        <= '0;
            r_j        <= 3'd0;
            r_rcon     <= 8'h01;
            r_p        <= 4'd0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_rk_out   <= 128'd0;
            r_rk_valid <= 1'b0;
            r_rk_index <= 4'd0;
            r_rk_last  <= 1'b0;
        end else begin
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
            if (key_load) begin
                r_state <= EXPAND;
                r_i     <= NK_I;
                r_j     <= 3'd0;
                r_rcon  <= 8'h01;
                r_busy  <= 1'b1;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    EXPAND: begin
                        if (r_j == 3'd0) begin
                            r_rcon <= xtime(r_rcon);
                        end
                        r_j <= (r_j == NK_J) ? 3'd0 : r_j + 3'd1;
                        if (r_i == LAST_I) begin
                            r_state <= READY;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_p     <= 4'(Nr);
                        end else begin
                            r_i <= r_i + IW'(1);
                        end
                    end
                    READY: begin
                        if (rk_req) begin
                            r_rk_out   <= {r_w[{r_p, 2'b00}], r_w[{r_p, 2'b01}],
                                           r_w[{r_p, 2'b10}], r_w[{r_p, 2'b11}]};
                            r_rk_index <= r_p;
                            r_rk_valid <= 1'b1;
                            r_rk_last  <= (r_p == 4'd0);
                            r_p        <= (r_p == 4'd0) ? 4'(Nr) : r_p - 4'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy     = r_busy;
    assign ready    = r_ready;
    assign rk_out   = r_rk_out;
    assign rk_valid = r_rk_valid;
    assign rk_index = r_rk_index;
    assign rk_last  = r_rk_last;
endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: AES-128 and AES-256 instances, known-answer round keys.
module tb_inv_key_schedule;
    logic         clk = 1'b0;
    logic         rst4, load4, req4, busy4, ready4, valid4, last4;
    logic [127:0] key4, out4;
    logic [3:0]   idx4;
    logic         rst8, load8, req8, busy8, ready8, valid8, last8;
    logic [255:0] key8;
    logic [127:0] out8;
    logic [3:0]   idx8;

    int checks = 0;
    int errors = 0;
    int n;
    logic seen;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    inv_key_schedule #(.Nk(4), .Nr(10)) dut4 (
        .clk(clk), .reset(rst4), .key_in(key4), .key_load(load4), .rk_req(req4),
        .busy(busy4), .ready(ready4), .rk_out(out4), .rk_valid(valid4),
        .rk_index(idx4), .rk_last(last4)
    );

    inv_key_schedule #(.Nk(8), .Nr(14)) dut8 (
        .clk(clk), .reset(rst8), .key_in(key8), .key_load(load8), .rk_req(req8),
        .busy(busy8), .ready(ready8), .rk_out(out8), .rk_valid(valid8),
        .rk_index(idx8), .rk_last(last8)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input bit sel, output int cnt);
        cnt = 0;
        while ((sel ? busy8 : busy4) === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic load_a4(input logic [127:0] k);
        @(negedge clk);
        key4 = k; load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
    endtask

    initial begin
        rst4 = 1'b1; rst8 = 1'b1; load4 = 1'b0; load8 = 1'b0; req4 = 1'b0; req8 = 1'b0;
        key4 = '0; key8 = '0;
        @(negedge clk); @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        check("reset_flags", 128'({busy4, ready4, valid4, last4}), 128'd0);
        check("reset_out", out4, 128'd0);
        check("reset_idx", 128'(idx4), 128'd0);

        // AES-128 expansion time and first served key
        load_a4(KEY_A);
        wait_busy(1'b0, n);
        check("busy_cycles_128", 128'(n), 128'd40);
        check("ready_128", 128'(ready4), 128'd1);
        req4 = 1'b1;
        @(negedge clk);
        req4 = 1'b0;
        check("first_valid", 128'(valid4), 128'd1);
        check("first_idx", 128'(idx4), 128'd10);
        check("first_key", out4, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("first_last", 128'(last4), 128'd0);
        @(negedge clk);
        check("strobe_width", 128'(valid4), 128'd0);
        check("out_hold", out4, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reload in READY with a simultaneous request: request dropped
        key4 = KEY_A; load4 = 1'b1; req4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0; req4 = 1'b0;
        check("reload_no_strobe", 128'(valid4), 128'd0);
        check("reload_ready_drop", 128'(ready4), 128'd0);
        wait_busy(1'b0, n);
        check("reload_busy_cycles", 128'(n), 128'd40);

        // 12 back-to-back requests: 10 down to 0, then wrap to 10
        req4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 11) req4 = 1'b0;
            check($sformatf("b2b_valid_%0d", k), 128'(valid4), 128'd1);
            check($sformatf("b2b_idx_%0d", k), 128'(idx4), 128'((k == 11) ? 10 : 10 - k));
            check($sformatf("b2b_last_%0d", k), 128'(last4), 128'((k == 10) ? 1 : 0));
            if (k == 1) check("b2b_key9", out4, 128'h549932d1f08557681093ed9cbe2c974e);
            if (k == 9) check("b2b_key1", out4, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
            if (k == 10) check("b2b_key0", out4, KEY_A);
            if (k == 11) check("b2b_wrap_key", out4, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        end

        // Requests during expansion ignored; restart with a new key mid-expansion
        load_a4(KEY_A);
        seen = 1'b0;
        req4 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid4 !== 1'b0) seen = 1'b1;
        end
        req4 = 1'b0;
        check("expand_no_strobe", 128'(seen), 128'd0);
        key4 = KEY_B; load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        wait_busy(1'b0, n);
        check("restart_busy_cycles", 128'(n), 128'd40);
        req4 = 1'b1;
        @(negedge clk);
        check("restart_idx", 128'(idx4), 128'd10);
        check("restart_key", out4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        // serve 9,8,7,6 so the pointer sits at 5
        for (int k = 0; k < 4; k++) @(negedge clk);
        req4 = 1'b0;
        check("pre_reset_idx", 128'(idx4), 128'd6);

        // Asynchronous reset while serving
        @(negedge clk);
        #2 rst4 = 1'b1;
        #1;
        check("async_rst_flags", 128'({busy4, ready4, valid4, last4}), 128'd0);
        check("async_rst_out", out4, 128'd0);
        check("async_rst_idx", 128'(idx4), 128'd0);
        @(negedge clk);
        rst4 = 1'b0;
        req4 = 1'b1;
        @(negedge clk);
        req4 = 1'b0;
        check("post_rst_no_strobe", 128'(valid4), 128'd0);
        check("post_rst_not_ready", 128'(ready4), 128'd0);
        load_a4(KEY_A);
        wait_busy(1'b0, n);
        check("post_rst_busy_cycles", 128'(n), 128'd40);
        req4 = 1'b1;
        @(negedge clk);
        req4 = 1'b0;
        check("post_rst_key", out4, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // AES-256 instance
        @(negedge clk);
        key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        wait_busy(1'b1, n);
        check("busy_cycles_256", 128'(n), 128'd52);
        check("ready_256", 128'(ready8), 128'd1);
        req8 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 14) req8 = 1'b0;
            check($sformatf("k256_idx_%0d", k), 128'(idx8), 128'(14 - k));
            if (k == 0) check("k256_key14", out8, 128'h24fc79ccbf0979e9371ac23c6d68de36);
            if (k == 13) check("k256_key1", out8, 128'h101112131415161718191a1b1c1d1e1f);
            if (k == 14) begin
                check("k256_key0", out8, 128'h000102030405060708090a0b0c0d0e0f);
                check("k256_last", 128'(last8), 128'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
